// File: rtl/gf180mcu_fd_sc_mcu7t5v0__arb4_rr.sv
// Four-requester round-robin arbiter with registered one-hot grants.
// Optional hold-limit preemption: GF180MCU_FD_SC_MCU7T5V0__ARB4_TIMEOUT_EN.
module gf180mcu_fd_sc_mcu7t5v0__arb4_rr #(
  parameter int MAX_HOLD = 15,
  parameter int CNT_W    = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [3:0] REQ,
  output logic [3:0] GNT,
  output logic [1:0] GNT_ID,
  output logic       VALID,
  output logic       ANY_REQ,
  output logic       TIMEOUT
);

  typedef enum logic {
    IDLE,
    OWNED
  } state_t;

  state_t     state;
  logic [1:0] ptr;
  logic [3:0] eff;
  logic [1:0] nxt_ptr;
  logic [2:0] sel_idle;
  logic [2:0] sel_rot;

  if (MAX_HOLD < 1 || MAX_HOLD > (1 << CNT_W) - 1) begin : g_bad_hold
    $error("MAX_HOLD does not fit the hold counter");
  end

  // First set bit of r searching p, p+1, p+2, p+3 (mod 4); {found, idx}.
  function automatic logic [2:0] pick(input logic [3:0] r,
                                      input logic [1:0] p);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      idx = p + 2'(i);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

`ifdef GF180MCU_FD_SC_MCU7T5V0__ARB4_TIMEOUT_EN
  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD);

  logic [CNT_W-1:0] cnt;
  logic [3:0]       mask;

  // Preempted owners stay ineligible until their request is seen low.
  assign eff = REQ & ~mask;
`else
  assign eff     = REQ;
  assign TIMEOUT = 1'b0;
`endif

  assign ANY_REQ  = |REQ;
  assign nxt_ptr  = GNT_ID + 2'd1;
  assign sel_idle = pick(eff, ptr);
  assign sel_rot  = pick(eff & ~GNT, nxt_ptr);

  // Ownership FSM: grant from idle, hold, rotate on release or preemption.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state  <= IDLE;
      ptr    <= 2'd0;
      GNT    <= 4'b0000;
      GNT_ID <= 2'd0;
      VALID  <= 1'b0;
`ifdef GF180MCU_FD_SC_MCU7T5V0__ARB4_TIMEOUT_EN
      TIMEOUT <= 1'b0;
      cnt     <= '0;
      mask    <= 4'b0000;
`endif
    end else begin
`ifdef GF180MCU_FD_SC_MCU7T5V0__ARB4_TIMEOUT_EN
      TIMEOUT <= 1'b0;
      mask    <= mask & REQ;
`endif
      unique case (state)
        IDLE: begin
          if (sel_idle[2]) begin
            state  <= OWNED;
            GNT    <= 4'b0001 << sel_idle[1:0];
            GNT_ID <= sel_idle[1:0];
            VALID  <= 1'b1;
`ifdef GF180MCU_FD_SC_MCU7T5V0__ARB4_TIMEOUT_EN
            cnt    <= '0;
`endif
          end
        end
        OWNED: begin
          if (!REQ[GNT_ID]) begin
            ptr <= nxt_ptr;
            if (sel_rot[2]) begin
              GNT    <= 4'b0001 << sel_rot[1:0];
              GNT_ID <= sel_rot[1:0];
`ifdef GF180MCU_FD_SC_MCU7T5V0__ARB4_TIMEOUT_EN
              cnt    <= '0;
`endif
            end else begin
              state  <= IDLE;
              GNT    <= 4'b0000;
              GNT_ID <= 2'd0;
              VALID  <= 1'b0;
            end
          end
`ifdef GF180MCU_FD_SC_MCU7T5V0__ARB4_TIMEOUT_EN
          else if (cnt == HOLD_MAX && sel_rot[2]) begin
            ptr     <= nxt_ptr;
            GNT     <= 4'b0001 << sel_rot[1:0];
            GNT_ID  <= sel_rot[1:0];
            TIMEOUT <= 1'b1;
            mask    <= (mask & REQ) | GNT;
            cnt     <= '0;
          end else if (cnt != HOLD_MAX) begin
            cnt <= cnt + 1'b1;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__arb4_rr.sv
// Directed testbench for the four-requester round-robin arbiter.
// Expected grants are hand-derived from the round-robin search order.
module tb_gf180mcu_fd_sc_mcu7t5v0__arb4_rr;

`ifdef GF180MCU_FD_SC_MCU7T5V0__ARB4_TIMEOUT_EN
  localparam int MH = 3;
`else
  localparam int MH = 15;
`endif

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [3:0] REQ = 4'b0000;
  logic [3:0] GNT;
  logic [1:0] GNT_ID;
  logic       VALID;
  logic       ANY_REQ;
  logic       TIMEOUT;

  int total = 0;
  int bad   = 0;

  gf180mcu_fd_sc_mcu7t5v0__arb4_rr #(
    .MAX_HOLD(MH),
    .CNT_W   (4)
  ) dut (
    .CLK    (CLK),
    .RST    (RST),
    .REQ    (REQ),
    .GNT    (GNT),
    .GNT_ID (GNT_ID),
    .VALID  (VALID),
    .ANY_REQ(ANY_REQ),
    .TIMEOUT(TIMEOUT)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    REQ = 4'b0000;
    RST = 1'b1;
    step();
    RST = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] exp;
    REQ = 4'b1111;
    RST = 1'b1;
    step();
    step();
    total++;
    exp = {4'b0000, 2'd0, 1'b0, 1'b0};
    if ({GNT, GNT_ID, VALID, TIMEOUT} !== exp) begin
      bad++;
      $display("FAIL reset_state got=%b want=%b",
               {GNT, GNT_ID, VALID, TIMEOUT}, exp);
    end
    total++;
    if (ANY_REQ !== 1'b1) begin
      bad++;
      $display("FAIL reset_any_req got=%b want=1", ANY_REQ);
    end
    RST = 1'b0;
    step();
    total++;
    exp = {4'b0001, 2'd0, 1'b1, 1'b0};
    if ({GNT, GNT_ID, VALID, TIMEOUT} !== exp) begin
      bad++;
      $display("FAIL reset_release got=%b want=%b",
               {GNT, GNT_ID, VALID, TIMEOUT}, exp);
    end
  endtask

  task automatic test_any_req();
    logic [3:0] pats [5] = '{4'b0000, 4'b0001, 4'b0100,
                             4'b1000, 4'b1010};
    for (int i = 0; i < 5; i++) begin
      REQ = pats[i];
      #1;
      total++;
      if (ANY_REQ !== (pats[i] != 4'b0000)) begin
        bad++;
        $display("FAIL any_req req=%b got=%b want=%b",
                 pats[i], ANY_REQ, pats[i] != 4'b0000);
      end
    end
  endtask

  task automatic test_single();
    do_reset();
    REQ = 4'b0100;
    step();
    total++;
    if ({GNT, GNT_ID, VALID} !== {4'b0100, 2'd2, 1'b1}) begin
      bad++;
      $display("FAIL single_grant got=%b/%0d/%b want=0100/2/1",
               GNT, GNT_ID, VALID);
    end
    step();
    total++;
    if (GNT !== 4'b0100) begin
      bad++;
      $display("FAIL single_hold got=%b want=0100", GNT);
    end
    REQ = 4'b0000;
    step();
    total++;
    if ({GNT, GNT_ID, VALID} !== {4'b0000, 2'd0, 1'b0}) begin
      bad++;
      $display("FAIL single_release got=%b/%0d/%b want=0000/0/0",
               GNT, GNT_ID, VALID);
    end
  endtask

  task automatic test_rotation();
    logic [3:0] oh;
    do_reset();
    REQ = 4'b1111;
    step();
    for (int i = 0; i < 5; i++) begin
      oh = 4'b0001 << (i % 4);
      total++;
      if ({GNT, GNT_ID, VALID} !== {oh, 2'(i % 4), 1'b1}) begin
        bad++;
        $display("FAIL rotate_grant%0d got=%b/%0d/%b want=%b/%0d/1",
                 i, GNT, GNT_ID, VALID, oh, i % 4);
      end
      step();
      total++;
      if (GNT !== oh) begin
        bad++;
        $display("FAIL rotate_hold%0d got=%b want=%b", i, GNT, oh);
      end
      if (i < 4) begin
        REQ = 4'b1111 & ~oh;
        step();
        REQ = 4'b1111;
      end
    end
    REQ = 4'b0000;
    step();
  endtask

  task automatic test_wrap();
    do_reset();
    REQ = 4'b1000;
    step();
    total++;
    if (GNT !== 4'b1000) begin
      bad++;
      $display("FAIL wrap_owner3 got=%b want=1000", GNT);
    end
    REQ = 4'b0011;
    step();
    total++;
    if ({GNT, GNT_ID} !== {4'b0001, 2'd0}) begin
      bad++;
      $display("FAIL wrap_to0 got=%b/%0d want=0001/0", GNT, GNT_ID);
    end
    REQ = 4'b0000;
    step();
    total++;
    if (VALID !== 1'b0) begin
      bad++;
      $display("FAIL wrap_idle got=%b want=0", VALID);
    end
    REQ = 4'b1011;
    step();
    total++;
    if ({GNT, GNT_ID} !== {4'b0010, 2'd1}) begin
      bad++;
      $display("FAIL wrap_ptr1 got=%b/%0d want=0010/1", GNT, GNT_ID);
    end
    REQ = 4'b0000;
    step();
  endtask

  task automatic test_async_reset();
    do_reset();
    REQ = 4'b0100;
    step();
    total++;
    if (GNT !== 4'b0100) begin
      bad++;
      $display("FAIL async_pre got=%b want=0100", GNT);
    end
    #2;
    RST = 1'b1;
    #1;
    total++;
    if ({GNT, GNT_ID, VALID} !== {4'b0000, 2'd0, 1'b0}) begin
      bad++;
      $display("FAIL async_clear got=%b/%0d/%b want=0000/0/0",
               GNT, GNT_ID, VALID);
    end
    REQ = 4'b0110;
    #2;
    RST = 1'b0;
    step();
    total++;
    if ({GNT, GNT_ID} !== {4'b0010, 2'd1}) begin
      bad++;
      $display("FAIL async_rearb got=%b/%0d want=0010/1", GNT, GNT_ID);
    end
    REQ = 4'b0000;
    step();
  endtask

  task automatic test_timeout_off();
    do_reset();
    REQ = 4'b0001;
    step();
    REQ = 4'b0011;
    for (int i = 0; i < 20; i++) begin
      step();
`ifndef GF180MCU_FD_SC_MCU7T5V0__ARB4_TIMEOUT_EN
      total++;
      if ({GNT, TIMEOUT} !== {4'b0001, 1'b0}) begin
        bad++;
        $display("FAIL no_preempt%0d got=%b/%b want=0001/0",
                 i, GNT, TIMEOUT);
      end
`endif
    end
    REQ = 4'b0000;
    step();
  endtask

`ifdef GF180MCU_FD_SC_MCU7T5V0__ARB4_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    REQ = 4'b0001;
    step();
    REQ = 4'b0011;
    for (int i = 1; i <= 3; i++) begin
      step();
      total++;
      if ({GNT, TIMEOUT} !== {4'b0001, 1'b0}) begin
        bad++;
        $display("FAIL to_hold%0d got=%b/%b want=0001/0",
                 i, GNT, TIMEOUT);
      end
    end
    step();
    total++;
    if ({GNT, GNT_ID, TIMEOUT} !== {4'b0010, 2'd1, 1'b1}) begin
      bad++;
      $display("FAIL to_preempt got=%b/%0d/%b want=0010/1/1",
               GNT, GNT_ID, TIMEOUT);
    end
    step();
    total++;
    if ({GNT, TIMEOUT} !== {4'b0010, 1'b0}) begin
      bad++;
      $display("FAIL to_pulse got=%b/%b want=0010/0", GNT, TIMEOUT);
    end
    REQ = 4'b0001;
    step();
    step();
    total++;
    if (VALID !== 1'b0) begin
      bad++;
      $display("FAIL to_masked got=%b want=0", VALID);
    end
    REQ = 4'b0000;
    step();
    REQ = 4'b0001;
    step();
    total++;
    if (GNT !== 4'b0001) begin
      bad++;
      $display("FAIL to_unmask got=%b want=0001", GNT);
    end
    for (int i = 0; i < 8; i++) begin
      step();
      total++;
      if ({GNT, TIMEOUT} !== {4'b0001, 1'b0}) begin
        bad++;
        $display("FAIL to_alone%0d got=%b/%b want=0001/0",
                 i, GNT, TIMEOUT);
      end
    end
    REQ = 4'b0000;
    step();
  endtask
`endif

  initial begin
    test_reset();
    test_any_req();
    test_single();
    test_rotation();
    test_wrap();
    test_async_reset();
    test_timeout_off();
`ifdef GF180MCU_FD_SC_MCU7T5V0__ARB4_TIMEOUT_EN
    test_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
